ecg_axis_packetizer: RTL and testbench

Downstream consumer of the CSR-gated sample FIFO. It drains FIFO words through the FIFO read port and emits them as fixed-length AXI4-Stream frames, with TLAST on the final sample of each frame. A 2-entry output buffer absorbs TREADY backpressure without losing FIFO data. Frames start only while `enable` (driven from the CSR CONTROL bit) is high; a frame in progress always completes.

---
 rtl/ecg_axis_packetizer.sv | 138 +++++++++++++
 tb/tb_ecg_axis_packetizer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_axis_packetizer.sv
// Drains the sample FIFO into fixed-length AXI4-Stream frames through a 2-entry skid buffer.
// Optional SEQ_HEADER_EN prepends a {16'hEC60, frame_cnt} header beat to every frame.
module ecg_axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam logic [15:0] LP_LEN  = 16'(FRAME_LEN);
    localparam logic [15:0] LP_LAST = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1
`ifdef SEQ_HEADER_EN
        , HDR = 2'd2
`endif
    } state_t;

    state_t                r_state;
    logic [15:0]           r_issued;
    logic [15:0]           r_frame_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [0:1];
    logic                  r_buf_last [0:1];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_buf_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [2:0]            w_occ;

`ifdef SEQ_HEADER_EN
    logic [DATA_WIDTH-1:0] w_hdr;
    assign w_hdr = DATA_WIDTH'({16'hEC60, r_frame_cnt});
`endif

    always_comb begin
        w_pop       = (r_buf_cnt != 2'd0) && M_AXIS_TREADY;
        // A pop in this cycle frees its slot, which is what sustains one word per cycle.
        w_occ       = 3'(r_buf_cnt) + 3'(r_inflight) - 3'(w_pop);
        w_rd_en     = (r_state == DATA) && !fifo_empty && (w_occ < 3'd2) && (r_issued < LP_LEN);
        w_push      = r_inflight;
        w_push_data = fifo_dout;
        w_push_last = r_inflight_last;
`ifdef SEQ_HEADER_EN
        if (r_state == HDR && r_buf_cnt != 2'd2) begin
            w_push      = 1'b1;
            w_push_data = w_hdr;
            w_push_last = 1'b0;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state         <= IDLE;
            r_issued        <= '0;
            r_frame_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_buf_cnt       <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_last[i] <= 1'b0;
            end
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && (r_issued == LP_LAST);
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= w_push_data;
                r_buf_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_buf_cnt <= r_buf_cnt + 2'(w_push) - 2'(w_pop);

            case (r_state)
                IDLE: begin
                    r_issued <= '0;
                    if (enable && !fifo_empty) begin
`ifdef SEQ_HEADER_EN
                        r_state <= HDR;
`else
                        r_state <= DATA;
`endif
                    end
                end
`ifdef SEQ_HEADER_EN
                HDR: begin
                    if (r_buf_cnt != 2'd2) begin
                        r_state <= DATA;
                    end
                end
`endif
                DATA: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + 16'd1;
                    end
                    if (w_pop && r_buf_last[r_rd_ptr]) begin
                        r_state     <= IDLE;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign M_AXIS_TDATA  = r_buf_data[r_rd_ptr];
    assign M_AXIS_TLAST  = r_buf_last[r_rd_ptr];
    assign M_AXIS_TVALID = (r_buf_cnt != 2'd0);
    assign busy          = (r_state != IDLE);
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_ecg_axis_packetizer.sv
// Directed bench for ecg_axis_packetizer with a behavioural 1-cycle-latency FIFO and beat monitor.
// Build with SEQ_HEADER_EN defined to exercise the header beat instead of the plain-frame tests.
module tb_ecg_axis_packetizer;

    localparam int DW = 32;
    localparam int FL = 16;

    logic          ACLK;
    logic          ARESET;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;
    logic          busy;
    logic [15:0]   frame_cnt;

    int errors = 0;
    int checks = 0;

    ecg_axis_packetizer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Source FIFO model: read data appears one cycle after the strobe.
    logic [DW-1:0] mem [0:255];
    logic [7:0]    rd_idx = 8'd0;
    logic [7:0]    wr_idx = 8'd0;
    assign fifo_empty = (rd_idx == wr_idx);

    initial fifo_dout = '0;
    always @(posedge ACLK) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_idx];
            rd_idx    <= rd_idx + 8'd1;
        end
    end

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Monitor on the falling edge: records accepted beats and watches stalled beats for stability.
    logic [DW-1:0] bq_data [$];
    bit            bq_last [$];
    int            bq_cyc  [$];
    int            rd_cnt     = 0;
    int            stall_cnt  = 0;
    int            stall_viol = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge ACLK) begin
        if (ARESET) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_data ||
                               M_AXIS_TLAST !== prev_last))
                stall_viol++;
            if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY) begin
                bq_data.push_back(M_AXIS_TDATA);
                bq_last.push_back(M_AXIS_TLAST);
                bq_cyc.push_back(cyc);
            end
            if (fifo_rd_en === 1'b1) rd_cnt++;
            prev_stall = (M_AXIS_TVALID === 1'b1) && !M_AXIS_TREADY;
            if (prev_stall) stall_cnt++;
            prev_data = M_AXIS_TDATA;
            prev_last = M_AXIS_TLAST;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx] = DW'(first + i);
            wr_idx      = wr_idx + 8'd1;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frame_cnt != 16'(target); i++) step(1);
    endtask

    task automatic do_reset();
        ARESET        = 1'b1;
        enable        = 1'b0;
        M_AXIS_TREADY = 1'b1;
        step(2);
        wr_idx = rd_idx;
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        ARESET        = 1'b1;
        enable        = 1'b1;
        M_AXIS_TREADY = 1'b1;
        push_words(1, 4);
        step(3);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", M_AXIS_TVALID); end
        checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", M_AXIS_TLAST); end
        checks++; if (M_AXIS_TDATA !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", M_AXIS_TDATA); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        do_reset();
    endtask

    task automatic test_basic();
        int b, c0;
        do_reset();
        push_words(1, 16);
        b = bq_data.size();
        enable = 1'b1;
        c0 = cyc;
        wait_frames(1, 100);
        step(2);
        checks++; if (bq_data.size() - b !== 16) begin errors++; $display("FAIL basic_count: got %0d want 16", bq_data.size() - b); end
        checks++; if (bq_cyc[b] - c0 !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", bq_cyc[b] - c0); end
        checks++; if (bq_cyc[b+15] - bq_cyc[b] !== 15) begin errors++; $display("FAIL basic_throughput: got %0d want 15", bq_cyc[b+15] - bq_cyc[b]); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (bq_data[b+i] !== DW'(i + 1)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, bq_data[b+i], i + 1); end
            checks++; if (bq_last[b+i] !== (i == 15)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, bq_last[b+i], i == 15); end
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_enable_gate();
        int b, r0;
        do_reset();
        push_words(101, 16);
        b  = bq_data.size();
        r0 = rd_cnt;
        step(100);
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL gate_rd_en: got %0d reads want 0", rd_cnt - r0); end
        checks++; if (bq_data.size() - b !== 0) begin errors++; $display("FAIL gate_beats: got %0d want 0", bq_data.size() - b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy: got %b want 0", busy); end
        enable = 1'b1;
        wait_frames(1, 100);
        step(2);
        checks++; if (bq_data.size() - b !== 16) begin errors++; $display("FAIL gate_count: got %0d want 16", bq_data.size() - b); end
        checks++; if (bq_data[b] !== DW'(101)) begin errors++; $display("FAIL gate_first: got %h want %h", bq_data[b], 101); end
        checks++; if (bq_data[b+15] !== DW'(116) || bq_last[b+15] !== 1'b1) begin errors++; $display("FAIL gate_last: got %h/%b want %h/1", bq_data[b+15], bq_last[b+15], 116); end
    endtask

    task automatic test_backpressure();
        int b, sv0, sc0;
        do_reset();
        push_words(1, 32);
        b   = bq_data.size();
        sv0 = stall_viol;
        sc0 = stall_cnt;
        enable = 1'b1;
        for (int i = 0; i < 600 && frame_cnt != 16'd2; i++) begin
            M_AXIS_TREADY = (i % 4 == 0) || (i % 4 == 3);
            step(1);
        end
        M_AXIS_TREADY = 1'b1;
        step(3);
        checks++; if (bq_data.size() - b !== 32) begin errors++; $display("FAIL bp_count: got %0d want 32", bq_data.size() - b); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (bq_data[b+i] !== DW'(i + 1)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, bq_data[b+i], i + 1); end
            checks++; if (bq_last[b+i] !== (i == 15 || i == 31)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", i, bq_last[b+i], i == 15 || i == 31); end
        end
        checks++; if (stall_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol - sv0); end
        checks++; if ((stall_cnt > sc0) !== 1'b1) begin errors++; $display("FAIL bp_stalled: got %0d stall cycles want >0", stall_cnt - sc0); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_underrun();
        int b;
        do_reset();
        push_words(1, 10);
        b = bq_data.size();
        enable = 1'b1;
        step(40);
        checks++; if (bq_data.size() - b !== 10) begin errors++; $display("FAIL ur_partial: got %0d want 10", bq_data.size() - b); end
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL ur_tvalid: got %b want 0", M_AXIS_TVALID); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ur_busy: got %b want 1", busy); end
        push_words(11, 6);
        wait_frames(1, 100);
        step(2);
        checks++; if (bq_data.size() - b !== 16) begin errors++; $display("FAIL ur_count: got %0d want 16", bq_data.size() - b); end
        checks++; if (bq_data[b+10] !== DW'(11)) begin errors++; $display("FAIL ur_resume: got %h want %h", bq_data[b+10], 11); end
        checks++; if (bq_last[b+9] !== 1'b0) begin errors++; $display("FAIL ur_last9: got %b want 0", bq_last[b+9]); end
        checks++; if (bq_data[b+15] !== DW'(16) || bq_last[b+15] !== 1'b1) begin errors++; $display("FAIL ur_last: got %h/%b want %h/1", bq_data[b+15], bq_last[b+15], 16); end
    endtask

    task automatic test_enable_drop();
        int b, r0;
        do_reset();
        push_words(1, 20);
        b  = bq_data.size();
        r0 = rd_cnt;
        enable = 1'b1;
        for (int i = 0; i < 100 && bq_data.size() - b < 5; i++) step(1);
        enable = 1'b0;
        wait_frames(1, 100);
        step(20);
        checks++; if (bq_data.size() - b !== 16) begin errors++; $display("FAIL drop_count: got %0d want 16", bq_data.size() - b); end
        checks++; if (bq_data[b+15] !== DW'(16) || bq_last[b+15] !== 1'b1) begin errors++; $display("FAIL drop_last: got %h/%b want %h/1", bq_data[b+15], bq_last[b+15], 16); end
        checks++; if (rd_cnt - r0 !== 16) begin errors++; $display("FAIL drop_reads: got %0d want 16", rd_cnt - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL drop_fifo_left: got empty=%b want 0", fifo_empty); end
    endtask

    task automatic test_reset_midframe();
        int b;
        do_reset();
        push_words(1, 24);
        b = bq_data.size();
        enable = 1'b1;
        for (int i = 0; i < 100 && bq_data.size() - b < 18; i++) step(1);
        M_AXIS_TREADY = 1'b0;
        step(4);
        checks++; if (M_AXIS_TVALID !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got tvalid=%b busy=%b want 1/1", M_AXIS_TVALID, busy); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 1", frame_cnt); end
        ARESET = 1'b1;
        enable = 1'b0;
        step(1);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", M_AXIS_TVALID); end
        checks++; if (M_AXIS_TDATA !== '0 || M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL mid_tdata: got %h/%b want 0/0", M_AXIS_TDATA, M_AXIS_TLAST); end
        checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_busy: got busy=%b rd=%b want 0/0", busy, fifo_rd_en); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d want 0", frame_cnt); end
        ARESET        = 1'b0;
        M_AXIS_TREADY = 1'b1;
        step(5);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL mid_after: got tvalid=%b want 0", M_AXIS_TVALID); end
    endtask

`ifdef SEQ_HEADER_EN
    task automatic test_header();
        int b;
        do_reset();
        push_words(1, 32);
        b = bq_data.size();
        enable = 1'b1;
        wait_frames(2, 200);
        step(2);
        checks++; if (bq_data.size() - b !== 34) begin errors++; $display("FAIL hdr_count: got %0d want 34", bq_data.size() - b); end
        checks++; if (bq_data[b] !== 32'hEC600000 || bq_last[b] !== 1'b0) begin errors++; $display("FAIL hdr_first: got %h/%b want ec600000/0", bq_data[b], bq_last[b]); end
        checks++; if (bq_data[b+1] !== 32'd1) begin errors++; $display("FAIL hdr_data1: got %h want 1", bq_data[b+1]); end
        checks++; if (bq_last[b+15] !== 1'b0) begin errors++; $display("FAIL hdr_last15: got %b want 0", bq_last[b+15]); end
        checks++; if (bq_data[b+16] !== 32'd16 || bq_last[b+16] !== 1'b1) begin errors++; $display("FAIL hdr_last1: got %h/%b want 10/1", bq_data[b+16], bq_last[b+16]); end
        checks++; if (bq_data[b+17] !== 32'hEC600001) begin errors++; $display("FAIL hdr_second: got %h want ec600001", bq_data[b+17]); end
        checks++; if (bq_data[b+18] !== 32'd17) begin errors++; $display("FAIL hdr_data17: got %h want 11", bq_data[b+18]); end
        checks++; if (bq_data[b+33] !== 32'd32 || bq_last[b+33] !== 1'b1) begin errors++; $display("FAIL hdr_last2: got %h/%b want 20/1", bq_data[b+33], bq_last[b+33]); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL hdr_frame_cnt: got %0d want 2", frame_cnt); end
    endtask
`endif

    initial begin
        ARESET        = 1'b1;
        enable        = 1'b0;
        M_AXIS_TREADY = 1'b1;
        test_reset();
`ifdef SEQ_HEADER_EN
        test_header();
`else
        test_basic();
        test_enable_gate();
        test_backpressure();
        test_underrun();
        test_enable_drop();
        test_reset_midframe();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
